countdown_timer: RTL and testbench

//  Consumer end of the slow divided clock. Samples the 1 Hz toggle output (clk_1Hz) of the

---
 rtl/countdown_timer.sv | 117 +++++++++++
 tb/tb_countdown_timer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Countdown timer driven by a synchronized 1 Hz toggle clock: tick generation, load/start/pause FSM, done pulse.
// Optional macro COUNTDOWN_BOTH_EDGE_EN: tick on both synchronized edges (half-second resolution).
module countdown_timer #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             slow_clk_in,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [2:0] WARM_LEN = 3'(SYNC_STAGES + 1);

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [2:0]             warm_cnt;
    logic                   warm_done;
    logic                   sync_out;
    logic                   edge_raw;
    logic                   tick_nxt;
    logic [CNT_W-1:0]       count_nxt;
    logic                   done_nxt;

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_cnt == WARM_LEN);

`ifdef COUNTDOWN_BOTH_EDGE_EN
    assign edge_raw = sync_out ^ hist_q;
`else
    assign edge_raw = sync_out & ~hist_q;
`endif

    // The chain resets to 0, so a level already high at reset looks like an edge; warm-up masks it.
    assign tick_nxt = edge_raw & warm_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            hist_q   <= 1'b0;
            warm_cnt <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk_in};
            hist_q <= sync_out;
            if (!warm_done)
                warm_cnt <= warm_cnt + 3'd1;
        end
    end

    // Priority: load > tick > pause > start; pause also blocks a same-cycle start.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        done_nxt  = 1'b0;
        if (load) begin
            count_nxt = load_val;
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !pause && count != '0)
                        state_nxt = RUN;
                end
                RUN: begin
                    if (tick_nxt) begin
                        if (count == CNT_W'(1)) begin
                            count_nxt = '0;
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end else if (count != '0) begin
                            count_nxt = count - CNT_W'(1);
                            if (pause)
                                state_nxt = PAUSE;
                        end
                    end else if (pause) begin
                        state_nxt = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start && !pause)
                        state_nxt = RUN;
                end
                DONE: begin
                    count_nxt = '0;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            done    <= 1'b0;
            running <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            done    <= done_nxt;
            running <= (state_nxt == RUN);
            tick    <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer; define COUNTDOWN_BOTH_EDGE_EN for the both-edge build.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       slow_clk_in;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic       tick;
    logic [7:0] count;
    logic       running;
    logic       done;

    int n_chk = 0;
    int n_bad = 0;

    countdown_timer #(.CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .slow_clk_in(slow_clk_in),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .pause      (pause),
        .tick       (tick),
        .count      (count),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        load_val = v;
        load     = 1'b1;
        cyc(1);
        load     = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // Rise slow_clk_in; tick must show exactly 3 cycles later with the expected count.
    task automatic slow_rise(input string tag, input logic [7:0] exp_cnt);
        slow_clk_in = 1'b1;
        cyc(2);
        chk({tag, "_early"}, tick, 0);
        cyc(1);
        chk({tag, "_tick"}, tick, 1);
        chk({tag, "_cnt"}, count, exp_cnt);
    endtask

    task automatic slow_fall();
        slow_clk_in = 1'b0;
        cyc(4);
    endtask

    initial begin
        rst_n = 1'b0; slow_clk_in = 1'b1; load = 1'b0; load_val = '0;
        start = 1'b0; pause = 1'b0;

        // 1: reset with slow clock high, no false tick after release
        cyc(3);
        chk("rst_tick", tick, 0);
        chk("rst_count", count, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("warm_tick", tick, 0);
        end
        chk("warm_count", count, 0);
        chk("warm_running", running, 0);
        slow_fall();

`ifndef COUNTDOWN_BOTH_EDGE_EN
        // 2: load 3, count down to zero
        do_load(8'd3);
        chk("t2_load", count, 3);
        chk("t2_idle", running, 0);
        do_start();
        chk("t2_run", running, 1);
        slow_rise("t2_r1", 8'd2);
        chk("t2_r1_done", done, 0);
        slow_fall();
        slow_rise("t2_r2", 8'd1);
        slow_fall();
        slow_rise("t2_r3", 8'd0);
        chk("t2_done", done, 1);
        chk("t2_run_drop", running, 0);
        cyc(1);
        chk("t2_done_pulse", done, 0);
        chk("t2_hold0", count, 0);
        do_start();
        chk("t2_done_nostart", running, 0);
        slow_fall();
        slow_rise("t2_after", 8'd0);
        slow_fall();

        // 3: pause discards ticks, start resumes
        do_load(8'd5);
        do_start();
        slow_rise("t3_r1", 8'd4);
        slow_fall();
        slow_rise("t3_r2", 8'd3);
        slow_fall();
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        chk("t3_paused", running, 0);
        slow_rise("t3_p1", 8'd3);
        slow_fall();
        slow_rise("t3_p2", 8'd3);
        slow_fall();
        do_start();
        chk("t3_resume", running, 1);
        slow_rise("t3_r3", 8'd2);
        slow_fall();

        // 4: load beats a same-cycle tick; start with count 0 stays idle
        load_val    = 8'd9;
        slow_clk_in = 1'b1;
        cyc(2);
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("t4_tick", tick, 1);
        chk("t4_count", count, 9);
        chk("t4_idle", running, 0);
        chk("t4_nodone", done, 0);
        slow_fall();
        do_load(8'd0);
        do_start();
        chk("t4_zero_start", running, 0);
        chk("t4_zero_count", count, 0);

        // 5: reset mid-run, warm-up masks an immediate rise
        do_load(8'd5);
        do_start();
        slow_rise("t5_r1", 8'd4);
        slow_fall();
        chk("t5_pre_run", running, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_count", count, 0);
        chk("t5_rst_running", running, 0);
        chk("t5_rst_tick", tick, 0);
        chk("t5_rst_done", done, 0);
        cyc(2);
        rst_n       = 1'b1;
        slow_clk_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("t5_warm_tick", tick, 0);
        end
        slow_fall();
        slow_rise("t5_post", 8'd0);
        chk("t5_post_idle", running, 0);
        slow_fall();
`else
        // 6: both edges tick, 2 periods take 4 down to 0
        slow_clk_in = 1'b0;
        cyc(4);
        do_load(8'd4);
        do_start();
        chk("t6_run", running, 1);
        for (int i = 0; i < 4; i++) begin
            slow_clk_in = ~slow_clk_in;
            cyc(2);
            chk("t6_early", tick, 0);
            cyc(1);
            chk("t6_tick", tick, 1);
            chk("t6_count", count, 32'(3 - i));
            chk("t6_done", done, (i == 3) ? 1 : 0);
            cyc(2);
            chk("t6_done_pulse", done, 0);
        end
        chk("t6_running", running, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
